// File: rtl/alu4_nibble_sequencer.sv
// Multi-nibble sequencer around a 4-bit combinational ALU: slices one W-bit
// operation into nibbles, chains carries between them and assembles the result.
module alu4_nibble_sequencer #(
  parameter int NIBBLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [3:0]             i_op,
  input  logic [4*NIBBLES-1:0]   i_opa,
  input  logic [4*NIBBLES-1:0]   i_opb,
  input  logic                   i_cin_math,
  input  logic                   i_cin_rot,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_result,
  output logic                   o_cout_math,
  output logic                   o_cout_rot,
  output logic                   o_zero,
  output logic                   o_overflow,
  output logic [3:0]             o_alu_op,
  output logic [3:0]             o_alu_a,
  output logic [3:0]             o_alu_b,
  output logic                   o_alu_mci,
  output logic                   o_alu_rci,
  input  logic [3:0]             i_alu_out,
  input  logic                   i_alu_mco,
  input  logic                   i_alu_rco,
  input  logic                   i_alu_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  localparam logic [1:0] C_OTHER = 2'd0;
  localparam logic [1:0] C_RIGHT = 2'd1;
  localparam logic [1:0] C_LEFT  = 2'd2;
  localparam logic [1:0] C_MATH  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [1:0] op_class(input logic [3:0] op);
    case (op)
      4'hB, 4'hD, 4'hF: op_class = C_RIGHT;
      4'hC, 4'hE:       op_class = C_LEFT;
      4'h0, 4'h4, 4'h5: op_class = C_MATH;
      default:          op_class = C_OTHER;
    endcase
  endfunction

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic [3:0]      r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cm;
  logic            r_cr;
  logic            r_prev_mco;
  logic            r_prev_rco;
  logic [W-1:0]    r_acc;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_result;
  logic            r_cout_math;
  logic            r_cout_rot;
  logic            r_zero;
  logic            r_overflow;

  logic [1:0]      w_cls;
  logic            w_first;
  logic [KW-1:0]   w_pos;
  logic [KW+1:0]   w_sh;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic [W-1:0]    w_full;
  logic [3:0]      w_alu_op;
  logic [3:0]      w_alu_a;
  logic [3:0]      w_alu_b;
  logic            w_alu_mci;
  logic            w_alu_rci;

  // Right-class ops walk from the MSB nibble down; everything else walks up.
  assign w_cls   = op_class(r_op);
  assign w_first = (r_k == {KW{1'b0}});
  assign w_pos   = (w_cls == C_RIGHT) ? (K_LAST - r_k) : r_k;
  assign w_sh    = {w_pos, 2'b00};
  assign w_nib_a = 4'(r_a >> w_sh);
  assign w_nib_b = 4'(r_b >> w_sh);
  assign w_full  = (r_acc & ~(W'(4'hF) << w_sh)) | (W'(i_alu_out) << w_sh);

  // ALU drive: per-class opcode and carry chaining, zero outside EXEC.
  always_comb begin
    w_alu_op  = 4'h0;
    w_alu_a   = 4'h0;
    w_alu_b   = 4'h0;
    w_alu_mci = 1'b0;
    w_alu_rci = 1'b0;
    if (r_state == S_EXEC) begin
      w_alu_a = w_nib_a;
      w_alu_b = w_nib_b;
      case (w_cls)
        C_RIGHT: begin
          w_alu_op  = w_first ? r_op : 4'hF;
          w_alu_mci = r_cm;
          w_alu_rci = w_first ? r_cr : r_prev_rco;
        end
        C_LEFT: begin
          w_alu_op  = w_first ? r_op : 4'hE;
          w_alu_mci = r_cm;
          w_alu_rci = w_first ? r_cr : r_prev_rco;
        end
        C_MATH: begin
          // Op 0 inverts its carry input inside the ALU, so pre-invert the chain.
          w_alu_op  = r_op;
          w_alu_mci = w_first ? r_cm : ((r_op == 4'h0) ? ~r_prev_mco : r_prev_mco);
          w_alu_rci = r_cr;
        end
        default: begin
          w_alu_op  = r_op;
          w_alu_mci = r_cm;
          w_alu_rci = r_cr;
        end
      endcase
    end else begin
      w_alu_op  = 4'h0;
      w_alu_a   = 4'h0;
      w_alu_b   = 4'h0;
      w_alu_mci = 1'b0;
      w_alu_rci = 1'b0;
    end
  end

  // Sequencer FSM: accept, step one nibble per cycle, publish result on DONE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_k         <= {KW{1'b0}};
      r_op        <= 4'h0;
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_cm        <= 1'b0;
      r_cr        <= 1'b0;
      r_prev_mco  <= 1'b0;
      r_prev_rco  <= 1'b0;
      r_acc       <= {W{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= {W{1'b0}};
      r_cout_math <= 1'b0;
      r_cout_rot  <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_EXEC;
            r_busy  <= 1'b1;
            r_k     <= {KW{1'b0}};
            r_op    <= i_op;
            r_a     <= i_opa;
            r_b     <= i_opb;
            r_cm    <= i_cin_math;
            r_cr    <= i_cin_rot;
            r_acc   <= {W{1'b0}};
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_EXEC: begin
          r_acc      <= w_full;
          r_prev_mco <= i_alu_mco;
          r_prev_rco <= i_alu_rco;
          if (r_k == K_LAST) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_result    <= w_full;
            r_zero      <= ~|w_full;
            r_cout_math <= i_alu_mco;
            r_cout_rot  <= i_alu_rco;
            r_overflow  <= (w_cls == C_MATH) ? i_alu_ovf : 1'b0;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_cout_math = r_cout_math;
  assign o_cout_rot  = r_cout_rot;
  assign o_zero      = r_zero;
  assign o_overflow  = r_overflow;
  assign o_alu_op    = w_alu_op;
  assign o_alu_a     = w_alu_a;
  assign o_alu_b     = w_alu_b;
  assign o_alu_mci   = w_alu_mci;
  assign o_alu_rci   = w_alu_rci;

endmodule

// File: doc/alu4_nibble_sequencer.md
Name: alu4_nibble_sequencer

Overview:
- Multi-nibble execution controller wrapped around the 4-bit combinational ALU.
- Accepts one W-bit operation (W = 4*NIBBLES) and slices it into nibbles, one nibble per cycle.
- Drives the ALU's opcode, operand and carry inputs, and captures the ALU outputs.
- Chains the math and rotate carries between nibbles, then assembles the W-bit result and flags.

Parameters:
NIBBLES, 2, number of 4-bit slices per operation (W = 4*NIBBLES, NIBBLES >= 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request; accepted only when busy=0
op  in  4  ALU opcode
opa  in  W  operand A
opb  in  W  operand B
cin_math  in  1  math carry in
cin_rot  in  1  rotate carry in
busy  out  1  high while nibbles are executing
done  out  1  one-cycle pulse; result and flags valid
result  out  W  assembled result, held until the next accept
cout_math  out  1  math carry out of the last nibble processed
cout_rot  out  1  rotate carry out of the last nibble processed
zero  out  1  result == 0 across all W bits
overflow  out  1  ALU overflow of the last nibble processed (math class only, else 0)
alu_op  out  4  opcode to the ALU
alu_a  out  4  A nibble to the ALU
alu_b  out  4  B nibble to the ALU
alu_mci  out  1  math carry in to the ALU
alu_rci  out  1  rotate carry in to the ALU
alu_out  in  4  ALU sum/result nibble
alu_mco  in  1  ALU math carry out
alu_rco  in  1  ALU rotate carry out
alu_ovf  in  1  ALU overflow

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state: state=IDLE.
- Reset values: busy, done, result, cout_math, cout_rot, zero, overflow all 0. alu_op, alu_a, alu_b, alu_mci and alu_rci are all 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC: on start. Latch op, opa, opb, cin_math and cin_rot. Set nibble index k=0.
- EXEC: one nibble per cycle. The alu_* outputs are combinational from registered state and the index. alu_out, alu_mco, alu_rco and alu_ovf are captured at the clock edge. After NIBBLES cycles -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE. If start=1 during DONE, go straight to EXEC with the new latch (back-to-back).
- busy: 1 only in EXEC. Start while busy=1 is ignored; latched operands do not change.
- Latency: start accepted at edge t -> done=1 in the cycle after edge t+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- alu_* outside EXEC are 0.
- Class RIGHT, op in {0xB, 0xD, 0xF}:
  - Order is MSB nibble first.
  - First nibble: alu_op = op, alu_rci = cin_rot.
  - Later nibbles: alu_op = 0xF, alu_rci = previous alu_rco.
  - alu_mci = cin_math on all nibbles.
- Class LEFT, op in {0xC, 0xE}:
  - Order is LSB nibble first.
  - First nibble: alu_op = op, alu_rci = cin_rot.
  - Later nibbles: alu_op = 0xE, alu_rci = previous alu_rco.
- Class MATH, op in {0x0, 0x4, 0x5}:
  - Order is LSB nibble first; alu_op = op on every nibble.
  - First nibble: alu_mci = cin_math.
  - Later nibbles: alu_mci = previous alu_mco. For op 0x0 the ALU inverts its carry input, so the sequencer feeds ~previous alu_mco instead.
- Class OTHER, all remaining opcodes:
  - Order is LSB nibble first; nibbles are independent.
  - alu_op = op, alu_mci = cin_math and alu_rci = cin_rot on every nibble.
- Result assembly: each captured alu_out goes to result[4*i+3:4*i] for the nibble being processed, i = physical nibble position.
- result, zero and the carry flags update only at the DONE transition. Partial results are never visible on result.
- Flags:
  - cout_math, cout_rot: taken from the final EXEC nibble. For RIGHT that is nibble 0; for all other classes it is nibble NIBBLES-1.
  - overflow: alu_ovf of nibble NIBBLES-1 for MATH; 0 otherwise.
  - zero: ~|result, computed on the assembled value.
- NIBBLES=1: single EXEC cycle. First-nibble rules apply; no chaining.
- Reset mid-EXEC: abort; no done pulse; every output returns to its reset value next cycle.
- Simultaneous rst and start: rst wins.

Test Plan:
All scenarios use NIBBLES=2 and a scripted mock ALU.
- MATH carry chain:
  - Stimulus: op=0x4, opa=0x3F, opb=0x01, cin_math=0. Mock returns (out=0x0, mco=1) then (out=0x4, mco=0).
  - ALU drive: cycle1 alu_a=F, alu_b=1, alu_mci=0; cycle2 alu_a=3, alu_b=0, alu_mci=1.
  - Outputs: result=0x40, cout_math=0, done two edges after accept.
- Op 0x0 carry inversion:
  - Stimulus: op=0x0. Mock returns mco=0 on nibble 0.
  - ALU drive: nibble 1 alu_mci=1.
- RIGHT shift:
  - Stimulus: op=0xD, opa=0xA5.
  - ALU drive: cycle1 alu_op=D, alu_a=A; cycle2 alu_op=F, alu_a=5, alu_rci = mock rco of cycle1.
  - Outputs: result nibble order correct; cout_rot = cycle2 rco.
- LEFT shift:
  - Stimulus: op=0xC, opa=0x81.
  - ALU drive: cycle1 alu_op=C, alu_a=1; cycle2 alu_op=E, alu_a=8, alu_rci = prior rco.
- Handshake:
  - Start asserted during EXEC is ignored; operands unchanged.
  - Start asserted in DONE enters EXEC next cycle; exactly one done per accepted op.
- Reset and zero flag:
  - rst during cycle2 of EXEC -> no done, all outputs 0.
  - Separate run, mock returning 0x0 on both nibbles -> zero=1, result=0x00.
